// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg
// Shared widths and the write-back request record used by the GRF
// write-back arbiter and its LLU result FIFO.
//   REG_W    : register index width
//   DATA_W   : write data width
//   PC_W     : instruction PC width (trace only)
//   wb_req_t : {a3 destination, wd data, pc}
package grf_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [PC_W-1:0]   pc;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
// Small circular buffer holding LLU write-back results until a GRF write
// slot is free. The per-entry valid bits and destination indices are exported
// so the parent can build the pending-write mask without extra storage.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : enqueue one request (caller guarantees not full)
//   pop                : dequeue the head (caller guarantees not empty)
//   head               : request at the read pointer
//   count              : number of occupied entries (0..DEPTH)
//   valid              : per-slot occupancy
//   ent_a3             : per-slot destination register
module wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_req_t                       push_data,
    input  logic                          pop,
    output wb_req_t                       head,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][REG_W-1:0]   ent_a3
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    // Slots are distinct whenever push and pop coincide (not full, not empty),
    // so the valid-bit updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by valid/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_a3[i] = mem[i].a3;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
// Shares the GRF single write port between the W-stage pipeline write and
// buffered long-latency-unit results. The pipeline wins by default; a FIFO
// head that keeps losing is eventually forced through by stalling the
// pipeline for one cycle. GRF port outputs are registered (one cycle after
// the issue decision).
// Optional feature macro: WBA_TRACE_EN (prints each committed write).
// Ports:
//   WBA_clk_W_i, WBA_rstn_W_i               : clock, async active-low reset
//   WBA_pwe/pa3/pwd/ppc_W_i                  : pipeline write request
//   WBA_lvalid/la3/lwd/lpc_W_i, WBA_lready_W_o : LLU result handshake
//   WBA_stall_W_o                            : pipeline must hold its request
//   WBA_busy_W_o                             : registers with pending LLU write
//   WBA_gwe/ga3/gwd/gpc_W_o                  : registered GRF write port
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              WBA_clk_W_i,
    input  logic              WBA_rstn_W_i,
    input  logic              WBA_pwe_W_i,
    input  logic [4:0]        WBA_pa3_W_i,
    input  logic [31:0]       WBA_pwd_W_i,
    input  logic [31:0]       WBA_ppc_W_i,
    input  logic              WBA_lvalid_W_i,
    output logic              WBA_lready_W_o,
    input  logic [4:0]        WBA_la3_W_i,
    input  logic [31:0]       WBA_lwd_W_i,
    input  logic [31:0]       WBA_lpc_W_i,
    output logic              WBA_stall_W_o,
    output logic [31:0]       WBA_busy_W_o,
    output logic              WBA_gwe_W_o,
    output logic [4:0]        WBA_ga3_W_o,
    output logic [31:0]       WBA_gwd_W_o,
    output logic [31:0]       WBA_gpc_W_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    wb_req_t                     pipe_req;
    wb_req_t                     llu_req;
    wb_req_t                     head;
    wb_req_t                     sel_req;
    logic [CNT_W-1:0]            count;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][REG_W-1:0] ent_a3;
    logic                        fifo_empty;
    logic                        push;
    logic                        issue_head;
    logic                        issue_pipe;
    logic [SC_W-1:0]             starve_cnt;

    assign pipe_req.a3 = WBA_pa3_W_i;
    assign pipe_req.wd = WBA_pwd_W_i;
    assign pipe_req.pc = WBA_ppc_W_i;
    assign llu_req.a3  = WBA_la3_W_i;
    assign llu_req.wd  = WBA_lwd_W_i;
    assign llu_req.pc  = WBA_lpc_W_i;

    // Ready depends only on the registered count: a full FIFO refuses a push
    // even if the head is popped in the same cycle.
    assign WBA_lready_W_o = (count != CNT_W'(DEPTH));
    assign push           = WBA_lvalid_W_i && WBA_lready_W_o;
    assign fifo_empty     = (count == '0);
    assign WBA_stall_W_o  = (starve_cnt == SC_W'(STARVE_MAX));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (WBA_clk_W_i),
        .rst_n     (WBA_rstn_W_i),
        .push      (push),
        .push_data (llu_req),
        .pop       (issue_head),
        .head      (head),
        .count     (count),
        .valid     (valid),
        .ent_a3    (ent_a3)
    );

    // One write slot per cycle: a forced stall gives it to the FIFO head,
    // otherwise the pipeline, otherwise any waiting LLU result.
    always_comb begin
        issue_head = !fifo_empty && (WBA_stall_W_o || !WBA_pwe_W_i);
        issue_pipe = !WBA_stall_W_o && WBA_pwe_W_i;
        sel_req    = issue_head ? head : pipe_req;
    end

    // Counts cycles the current head has waited; saturates so the stall
    // decode stays asserted for exactly the cycle the head is forced out.
    always_ff @(posedge WBA_clk_W_i or negedge WBA_rstn_W_i) begin
        if (!WBA_rstn_W_i) begin
            starve_cnt <= '0;
        end else if (fifo_empty || issue_head) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Writes to $0 still consume their slot but never raise the enable.
    always_ff @(posedge WBA_clk_W_i or negedge WBA_rstn_W_i) begin
        if (!WBA_rstn_W_i) begin
            WBA_gwe_W_o <= 1'b0;
            WBA_ga3_W_o <= '0;
            WBA_gwd_W_o <= '0;
            WBA_gpc_W_o <= '0;
        end else begin
            WBA_gwe_W_o <= (issue_head || issue_pipe) && (sel_req.a3 != '0);
            if (issue_head || issue_pipe) begin
                WBA_ga3_W_o <= sel_req.a3;
                WBA_gwd_W_o <= sel_req.wd;
                WBA_gpc_W_o <= sel_req.pc;
            end
        end
    end

    always_comb begin
        WBA_busy_W_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (ent_a3[i] != '0)) begin
                WBA_busy_W_o[ent_a3[i]] = 1'b1;
            end
        end
    end

`ifdef WBA_TRACE_EN
    always @(posedge WBA_clk_W_i) begin
        if (WBA_rstn_W_i && WBA_gwe_W_o) begin
            $display("%d@%h: $%d <= %h", $time, WBA_gpc_W_o, WBA_ga3_W_o, WBA_gwd_W_o);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter
// Directed-vector bench for grf_wb_arbiter (DEPTH=2, STARVE_MAX=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, after registered outputs have settled.
module tb_grf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pwe;
    logic [4:0]  pa3;
    logic [31:0] pwd;
    logic [31:0] ppc;
    logic        lvalid;
    logic        lready;
    logic [4:0]  la3;
    logic [31:0] lwd;
    logic [31:0] lpc;
    logic        stall;
    logic [31:0] busy;
    logic        gwe;
    logic [4:0]  ga3;
    logic [31:0] gwd;
    logic [31:0] gpc;

    int vectors;
    int miscompares;

    grf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .WBA_clk_W_i    (clk),
        .WBA_rstn_W_i   (rst_n),
        .WBA_pwe_W_i    (pwe),
        .WBA_pa3_W_i    (pa3),
        .WBA_pwd_W_i    (pwd),
        .WBA_ppc_W_i    (ppc),
        .WBA_lvalid_W_i (lvalid),
        .WBA_lready_W_o (lready),
        .WBA_la3_W_i    (la3),
        .WBA_lwd_W_i    (lwd),
        .WBA_lpc_W_i    (lpc),
        .WBA_stall_W_o  (stall),
        .WBA_busy_W_o   (busy),
        .WBA_gwe_W_o    (gwe),
        .WBA_ga3_W_o    (ga3),
        .WBA_gwd_W_o    (gwd),
        .WBA_gpc_W_o    (gpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // PCs are derived from the data so gpc can be predicted.
    task automatic applyStimulus(input logic p_we, input logic [4:0] p_a3, input logic [31:0] p_wd,
                                 input logic l_v, input logic [4:0] l_a3, input logic [31:0] l_wd);
        pwe    = p_we;
        pa3    = p_a3;
        pwd    = p_wd;
        ppc    = 32'h1000 + p_wd;
        lvalid = l_v;
        la3    = l_a3;
        lwd    = l_wd;
        lpc    = 32'h2000 + l_wd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // reset state
        #12;
        checkOutput("rst_gwe", 32'(gwe), 32'd0);
        checkOutput("rst_ga3", 32'(ga3), 32'd0);
        checkOutput("rst_gwd", gwd, 32'd0);
        checkOutput("rst_gpc", gpc, 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_lready", 32'(lready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // single LLU write with idle pipeline
        applyStimulus(0, 0, 0, 1, 5, 32'h1234);
        checkOutput("t1_lready", 32'(lready), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_busy_c2", busy, 32'h0000_0020);
        checkOutput("t1_gwe_c2", 32'(gwe), 32'd0);
        nextCycle();
        checkOutput("t1_gwe_c3", 32'(gwe), 32'd1);
        checkOutput("t1_ga3_c3", 32'(ga3), 32'd5);
        checkOutput("t1_gwd_c3", gwd, 32'h1234);
        checkOutput("t1_gpc_c3", gpc, 32'h3234);
        checkOutput("t1_busy_c3", busy, 32'd0);
        nextCycle();
        checkOutput("t1_gwe_c4", 32'(gwe), 32'd0);

        // pipeline and LLU in the same cycle
        applyStimulus(1, 3, 32'hAAAA, 1, 7, 32'h7777);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2_gwe_c2", 32'(gwe), 32'd1);
        checkOutput("t2_ga3_c2", 32'(ga3), 32'd3);
        checkOutput("t2_gwd_c2", gwd, 32'hAAAA);
        checkOutput("t2_gpc_c2", gpc, 32'h1000 + 32'hAAAA);
        checkOutput("t2_busy_c2", busy, 32'h0000_0080);
        nextCycle();
        checkOutput("t2_gwe_c3", 32'(gwe), 32'd1);
        checkOutput("t2_ga3_c3", 32'(ga3), 32'd7);
        checkOutput("t2_gwd_c3", gwd, 32'h7777);
        checkOutput("t2_busy_c3", busy, 32'd0);
        nextCycle();
        checkOutput("t2_gwe_c4", 32'(gwe), 32'd0);

        // starvation: continuous pipeline writes, one LLU entry waiting
        applyStimulus(1, 1, 32'h100, 1, 9, 32'h9999);
        checkOutput("t3_lready", 32'(lready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            applyStimulus(1, 1, 32'h100 + 32'(k), 0, 0, 0);
            checkOutput("t3_stall_lo", 32'(stall), 32'd0);
            checkOutput("t3_pipe_ga3", 32'(ga3), 32'd1);
            checkOutput("t3_pipe_gwd", gwd, 32'h100 + 32'(k - 1));
        end
        nextCycle();
        applyStimulus(1, 1, 32'h105, 0, 0, 0);
        checkOutput("t3_stall_hi", 32'(stall), 32'd1);
        checkOutput("t3_gwd_c5", gwd, 32'h104);
        nextCycle();
        checkOutput("t3_stall_c6", 32'(stall), 32'd0);
        checkOutput("t3_gwe_c6", 32'(gwe), 32'd1);
        checkOutput("t3_ga3_c6", 32'(ga3), 32'd9);
        checkOutput("t3_gwd_c6", gwd, 32'h9999);
        checkOutput("t3_gpc_c6", gpc, 32'h2000 + 32'h9999);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_ga3_c7", 32'(ga3), 32'd1);
        checkOutput("t3_gwd_c7", gwd, 32'h105);
        checkOutput("t3_busy_c7", busy, 32'd0);
        nextCycle();
        checkOutput("t3_gwe_c8", 32'(gwe), 32'd0);

        // FIFO full: third push refused until the first pop
        applyStimulus(1, 2, 32'h22, 1, 10, 32'hA1);
        checkOutput("t4_lready_m0", 32'(lready), 32'd1);
        nextCycle();
        applyStimulus(1, 2, 32'h22, 1, 11, 32'hA2);
        checkOutput("t4_lready_m1", 32'(lready), 32'd1);
        checkOutput("t4_busy_m1", busy, 32'h0000_0400);
        nextCycle();
        applyStimulus(1, 2, 32'h22, 1, 12, 32'hA3);
        checkOutput("t4_lready_m2", 32'(lready), 32'd0);
        checkOutput("t4_busy_m2", busy, 32'h0000_0C00);
        nextCycle();
        checkOutput("t4_lready_m3", 32'(lready), 32'd0);
        checkOutput("t4_stall_m3", 32'(stall), 32'd0);
        nextCycle();
        checkOutput("t4_lready_m4", 32'(lready), 32'd0);
        checkOutput("t4_stall_m4", 32'(stall), 32'd0);
        nextCycle();
        checkOutput("t4_lready_m5", 32'(lready), 32'd0);
        checkOutput("t4_stall_m5", 32'(stall), 32'd1);
        nextCycle();
        checkOutput("t4_lready_m6", 32'(lready), 32'd1);
        checkOutput("t4_ga3_m6", 32'(ga3), 32'd10);
        checkOutput("t4_gwd_m6", gwd, 32'hA1);
        checkOutput("t4_stall_m6", 32'(stall), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_busy_m7", busy, 32'h0000_1800);
        checkOutput("t4_ga3_m7", 32'(ga3), 32'd2);
        nextCycle();
        checkOutput("t4_ga3_m8", 32'(ga3), 32'd11);
        checkOutput("t4_gwd_m8", gwd, 32'hA2);
        nextCycle();
        checkOutput("t4_ga3_m9", 32'(ga3), 32'd12);
        checkOutput("t4_gwd_m9", gwd, 32'hA3);
        checkOutput("t4_busy_m9", busy, 32'd0);
        nextCycle();
        checkOutput("t4_gwe_m10", 32'(gwe), 32'd0);

        // LLU write to $0
        applyStimulus(0, 0, 0, 1, 0, 32'hDEAD);
        checkOutput("t5_lready", 32'(lready), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_busy", busy, 32'd0);
        checkOutput("t5_gwe_c2", 32'(gwe), 32'd0);
        nextCycle();
        checkOutput("t5_gwe_c3", 32'(gwe), 32'd0);
        checkOutput("t5_lready_c3", 32'(lready), 32'd1);
        nextCycle();
        checkOutput("t5_gwe_c4", 32'(gwe), 32'd0);

        // asynchronous reset with two pending entries
        applyStimulus(1, 4, 32'h44, 1, 13, 32'hD1);
        nextCycle();
        applyStimulus(1, 4, 32'h44, 1, 14, 32'hD2);
        nextCycle();
        applyStimulus(1, 4, 32'h44, 0, 0, 0);
        checkOutput("t6_busy_pre", busy, 32'h0000_6000);
        checkOutput("t6_lready_pre", 32'(lready), 32'd0);
        checkOutput("t6_gwe_pre", 32'(gwe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy_rst", busy, 32'd0);
        checkOutput("t6_lready_rst", 32'(lready), 32'd1);
        checkOutput("t6_gwe_rst", 32'(gwe), 32'd0);
        checkOutput("t6_stall_rst", 32'(stall), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            checkOutput("t6_gwe_after", 32'(gwe), 32'd0);
            checkOutput("t6_busy_after", busy, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
